// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and helpers for the CPU load/store unit:
//   size_e      - request width encoding (3 is folded onto SZ_WORD)
//   state_e     - bus sequencing FSM states
//   norm_size   - maps the raw 2-bit size field onto size_e
//   is_misaligned - true when a half or word does not sit on its natural boundary
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUS   = 3'd1,
    RWAIT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // The CPU may present size 3; it behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] size);
    size_e result;
    case (size)
      2'd0:    result = SZ_BYTE;
      2'd1:    result = SZ_HALF;
      default: result = SZ_WORD;
    endcase
    return result;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    case (norm_size(size))
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = offset[0];
      default: result = (offset != 2'd0);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Purely combinational big-endian lane steering between the CPU and a 32-bit bus.
// Lane k of the bus word is bits [8k+7:8k] and holds the byte at word address + k;
// the numeric word value is {lane0, lane1, lane2, lane3}.
// Ports:
//   store_size/store_offset/store_wdata -> byteenable, writedata (disabled lanes 0)
//   load_size/load_offset/load_signed/readdata -> load_data (zero/sign extended)
// Misaligned combinations are not flagged here; the caller filters them.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  store_size,
  input  logic [1:0]  store_offset,
  input  logic [31:0] store_wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [1:0]  load_size,
  input  logic [1:0]  load_offset,
  input  logic        load_signed,
  input  logic [31:0] readdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store side: the most significant byte of a half/word goes on the lowest lane.
  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0;
    case (norm_size(store_size))
      SZ_BYTE: begin
        byteenable = 4'b0001 << store_offset;
        writedata  = {24'h0, store_wdata[7:0]} << {store_offset, 3'b000};
      end
      SZ_HALF: begin
        if (store_offset[1]) begin
          byteenable = 4'b1100;
          writedata  = {store_wdata[7:0], store_wdata[15:8], 16'h0};
        end else begin
          byteenable = 4'b0011;
          writedata  = {16'h0, store_wdata[7:0], store_wdata[15:8]};
        end
      end
      default: begin
        byteenable = 4'b1111;
        writedata  = {store_wdata[7:0], store_wdata[15:8],
                      store_wdata[23:16], store_wdata[31:24]};
      end
    endcase
  end

  // Load side: pick the addressed lanes, reassemble MSB-first, then extend.
  always_comb begin
    load_byte = readdata[{load_offset, 3'b000} +: 8];
    load_half = load_offset[1] ? {readdata[23:16], readdata[31:24]}
                               : {readdata[7:0],   readdata[15:8]};
    case (norm_size(load_size))
      SZ_BYTE: load_data = {{24{load_signed & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{load_signed & load_half[15]}}, load_half};
      default: load_data = {readdata[7:0], readdata[15:8],
                            readdata[23:16], readdata[31:24]};
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns one CPU load/store request into a single Avalon-style bus transaction.
// Ports:
//   clk, reset                 - rising-edge clock, async active-high reset
//   req_*                      - CPU request handshake (valid/ready) and fields
//   resp_valid/rdata/err       - one-cycle completion pulse with load data or error
//   address/read/write/byteenable/writedata/readdata/waitrequest - bus master side
// Parameter READ_LATENCY (1..3): edges from accepted read to valid readdata.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_e      state;
  state_e      state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic        write_q;
  logic [1:0]  lat_cnt;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        accept;
  logic        misaligned;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);

  // Store lanes are computed from the live request at accept time; load
  // extraction works from the registered request while readdata arrives.
  mem_lane_align u_align (
    .store_size   (req_size),
    .store_offset (req_addr[1:0]),
    .store_wdata  (req_wdata),
    .byteenable   (align_be),
    .writedata    (align_wdata),
    .load_size    (size_q),
    .load_offset  (off_q),
    .load_signed  (signed_q),
    .readdata     (readdata),
    .load_data    (align_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes and handshake are decoded from state so that an async reset
  // drops them immediately without waiting for a clock edge.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          state_next = misaligned ? ERR : BUS;
        end
      end
      BUS: begin
        read  = !write_q;
        write = write_q;
        if (!waitrequest) begin
          state_next = write_q ? DONE : RWAIT;
        end
      end
      RWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request/bus registers: loaded once on accept and held through BUS so the
  // bus fields stay stable under waitrequest. Loads and errors never put
  // data on writedata, and a misaligned request enables no lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      be_q     <= 4'b0000;
      size_q   <= 2'd0;
      off_q    <= 2'd0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      lat_cnt  <= 2'd0;
    end else begin
      if (accept) begin
        addr_q   <= {req_addr[31:2], 2'b00};
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        signed_q <= req_signed;
        write_q  <= req_write;
        rdata_q  <= 32'h0;
        be_q     <= misaligned ? 4'b0000 : align_be;
        wdata_q  <= (misaligned || !req_write) ? 32'h0 : align_wdata;
      end
      if (state == BUS) begin
        lat_cnt <= 2'd0;
      end else if (state == RWAIT) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if ((state == RWAIT) && (lat_cnt == LAT_LAST)) begin
        rdata_q <= align_rdata;
      end
    end
  end

  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Drives directed and random load/store requests into mem_access_unit, acts as
// the bus slave backed by a 256-byte big-endian memory model, and compares bus
// fields, latency and response data against values computed from that model.
module tb_mem_access_unit;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;
  logic        waitrequest = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mem [256];
  logic [31:0] last_rdata;

  mem_access_unit #(.READ_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete request: present, accept, play bus slave, check response.
  task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int waits);
    int          n, o, cyc, strobes, accepted, wait_left, rd_cnt, exp_lat;
    logic        mis, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, lane_word, word_addr;

    n         = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    o         = int'(a[1:0]);
    mis       = (n == 2 && (o % 2) != 0) || (n == 4 && o != 0);
    word_addr = a - 32'(o);

    exp_be = 4'b0000;
    exp_wd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k >= o && k < o + n) begin
        exp_be[k]        = 1'b1;
        exp_wd[8*k +: 8] = 8'(wd >> (8 * (n - 1 - (k - o))));
      end
    end

    lane_word = 32'h0;
    for (int k = 0; k < 4; k++) lane_word[8*k +: 8] = mem[8'(word_addr + 32'(k))];

    exp_rd = 32'h0;
    if (!wr && !mis) begin
      for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(mem[8'(a + 32'(i))]);
      if (sgn && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8 * n)) - 32'h1);
    end
    exp_lat = mis ? 1 : 2 + waits + (wr ? 0 : LAT);

    @(negedge clk);
    waitrequest = 1'b0;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sgn;
    req_addr    = a;
    req_wdata   = wd;
    req_valid   = 1'b1;
    check_output("req_ready_idle", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    cyc = 0; strobes = 0; accepted = 0; rd_cnt = 0; wait_left = waits; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rd_cnt > 0) begin
        rd_cnt--;
        readdata = (rd_cnt == 0) ? lane_word : $urandom;
      end else begin
        readdata = $urandom;
      end
      check_output("rw_exclusive", {31'b0, read & write}, 32'h0);
      if (resp_valid) begin
        done       = 1'b1;
        last_rdata = resp_rdata;
        check_output("resp_latency", 32'(cyc), 32'(exp_lat));
        check_output("resp_err", {31'b0, resp_err}, {31'b0, mis});
        check_output("resp_rdata", resp_rdata, exp_rd);
      end else if (read || write) begin
        strobes++;
        check_output("strobe_kind", {31'b0, write}, {31'b0, wr});
        check_output("address", address, word_addr);
        check_output("byteenable", {28'b0, byteenable}, {28'b0, exp_be});
        if (wr) check_output("writedata", writedata, exp_wd);
        if (wait_left > 0) begin
          waitrequest = 1'b1;
          wait_left--;
        end else begin
          waitrequest = 1'b0;
          accepted++;
          if (!wr) rd_cnt = LAT;
        end
      end else begin
        waitrequest = 1'b0;
      end
    end
    check_output("resp_seen", {31'b0, done}, 32'h1);
    check_output("strobe_cycles", 32'(strobes), mis ? 32'h0 : 32'(waits + 1));
    check_output("bus_accepts", 32'(accepted), mis ? 32'h0 : 32'h1);

    @(negedge clk);
    check_output("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
    check_output("ready_after", {31'b0, req_ready}, 32'h1);

    if (wr && !mis) begin
      for (int k = 0; k < 4; k++)
        if (exp_be[k]) mem[8'(word_addr + 32'(k))] = exp_wd[8*k +: 8];
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h04] = 8'h24; mem[8'h05] = 8'h42; mem[8'h06] = 8'h00; mem[8'h07] = 8'h0a;
    mem[8'h21] = 8'h80;
    mem[8'h32] = 8'h81; mem[8'h33] = 8'h23;

    // Reset values while reset is held.
    #3;
    check_output("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check_output("rst_read", {31'b0, read}, 32'h0);
    check_output("rst_write", {31'b0, write}, 32'h0);
    check_output("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_output("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check_output("rst_resp_rdata", resp_rdata, 32'h0);
    check_output("rst_address", address, 32'h0);
    check_output("rst_byteenable", {28'b0, byteenable}, 32'h0);
    check_output("rst_writedata", writedata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // lw from the boot vector region.
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'h0, 0);
    check_output("lw_boot_value", last_rdata, 32'h2442000a);
    // sb to lane 3.
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'h00000013, 32'hDEADBEEF, 0);
    // lb / lbu on 0x80, lh / lhu on 0x8123.
    apply_stimulus(1'b0, 2'd0, 1'b1, 32'h00000021, 32'h0, 0);
    check_output("lb_signed", last_rdata, 32'hFFFFFF80);
    apply_stimulus(1'b0, 2'd0, 1'b0, 32'h00000021, 32'h0, 0);
    check_output("lbu_unsigned", last_rdata, 32'h00000080);
    apply_stimulus(1'b0, 2'd1, 1'b1, 32'h00000032, 32'h0, 0);
    check_output("lh_signed", last_rdata, 32'hFFFF8123);
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h00000032, 32'h0, 0);
    check_output("lhu_unsigned", last_rdata, 32'h00008123);
    // sw under four cycles of waitrequest, then read it back as size 3.
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h00000040, 32'h11223344, 4);
    apply_stimulus(1'b0, 2'd3, 1'b0, 32'h00000040, 32'h0, 1);
    check_output("sw_readback", last_rdata, 32'h11223344);
    // sh at offset 2 then lhu of it.
    apply_stimulus(1'b1, 2'd1, 1'b0, 32'h00000052, 32'hCAFEA55A, 0);
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h00000052, 32'h0, 0);
    check_output("sh_readback", last_rdata, 32'h0000A55A);
    // Misaligned accesses.
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h00000001, 32'h0, 0);
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'h00000002, 32'h0, 0);
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h00000003, 32'h12345678, 0);

    // Reset while a read is stalled on the bus.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_addr = 32'h00000080; req_valid = 1'b1;
    waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_output("abort_read_high", {31'b0, read}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_output("abort_read_drop", {31'b0, read}, 32'h0);
    check_output("abort_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("abort_no_resp", {31'b0, resp_valid}, 32'h0);
      check_output("abort_no_read", {31'b0, read}, 32'h0);
      check_output("abort_ready_after", {31'b0, req_ready}, 32'h1);
    end

    // Random traffic, mostly aligned.
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      apply_stimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                     $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
